// File: rtl/mis_stim_gen.sv
// mis_stim_gen: two-input skewed-edge stimulus generator for NOR MIS tests.
// Drives myinA1/myinA2 through a settle period at !dir, a leading edge (with a
// scope trigger), a programmable skew to the trailing edge, and a hold period.
// Optional feature macro MIS_SWEEP_EN: adds delta_end and sweeps the skew from
// delta up to delta_end in steps of one, one edge pair per step.
`timescale 1ns/1ps

module mis_stim_gen #(
   parameter int CNT_W      = 8,
   parameter int SETTLE_MIN = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic signed [CNT_W-1:0] delta,
   input  logic                    dir,
   input  logic        [CNT_W-1:0] settle,
`ifdef MIS_SWEEP_EN
   input  logic signed [CNT_W-1:0] delta_end,
`endif
   output logic                    myinA1,
   output logic                    myinA2,
   output logic                    trig,
   output logic                    busy,
   output logic                    done
);

   // A zero-length settle would leave no ARM cycle to drive !dir, so the
   // effective floor is never below one cycle.
   localparam int SMIN_I = (SETTLE_MIN < 1) ? 1 : SETTLE_MIN;
   localparam logic [CNT_W-1:0] SMIN = CNT_W'(SMIN_I);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARM   = 3'd1,
      LEAD  = 3'd2,
      SKEW  = 3'd3,
      TRAIL = 3'd4,
      HOLD  = 3'd5,
      FIN   = 3'd6
   } state_t;

   // Magnitude of a signed skew as an unsigned CNT_W value; the most negative
   // value maps to 2^(CNT_W-1), which still fits.
   function automatic logic [CNT_W-1:0] abs_skew(input logic signed [CNT_W-1:0] d);
      logic [CNT_W-1:0] u;
      u = d;
      return u[CNT_W-1] ? (~u + ONE) : u;
   endfunction

   // Settle length with the configured lower bound applied.
   function automatic logic [CNT_W-1:0] sat_settle(input logic [CNT_W-1:0] s);
      return (s < SMIN) ? SMIN : s;
   endfunction

   state_t                  state, state_nx;
   logic        [CNT_W-1:0] cnt, cnt_nx;
   logic                    a1_nx, a2_nx, trig_nx, busy_nx, done_nx;
   logic                    dir_l, dir_l_nx;
   logic signed [CNT_W-1:0] dlt_l, dlt_l_nx;
   logic        [CNT_W-1:0] set_l, set_l_nx;
   logic        [CNT_W-1:0] skew;
   logic                    dlt_zero, dlt_neg;
   logic                    more_pairs;
`ifdef MIS_SWEEP_EN
   logic signed [CNT_W-1:0] dend_l, dend_l_nx;
`endif

   assign skew     = abs_skew(dlt_l);
   assign dlt_zero = (dlt_l == '0);
   assign dlt_neg  = dlt_l[CNT_W-1];
`ifdef MIS_SWEEP_EN
   assign more_pairs = (dlt_l < dend_l);
`else
   assign more_pairs = 1'b0;
`endif

   // State, counter, latched run parameters and all outputs are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         myinA1 <= 1'b0;
         myinA2 <= 1'b0;
         trig   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         dir_l  <= 1'b0;
         dlt_l  <= '0;
         set_l  <= '0;
`ifdef MIS_SWEEP_EN
         dend_l <= '0;
`endif
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         myinA1 <= a1_nx;
         myinA2 <= a2_nx;
         trig   <= trig_nx;
         busy   <= busy_nx;
         done   <= done_nx;
         dir_l  <= dir_l_nx;
         dlt_l  <= dlt_l_nx;
         set_l  <= set_l_nx;
`ifdef MIS_SWEEP_EN
         dend_l <= dend_l_nx;
`endif
      end
   end

   // Next-state and next-output logic; every value holds unless a state acts.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      a1_nx    = myinA1;
      a2_nx    = myinA2;
      trig_nx  = 1'b0;
      busy_nx  = busy;
      done_nx  = 1'b0;
      dir_l_nx = dir_l;
      dlt_l_nx = dlt_l;
      set_l_nx = set_l;
`ifdef MIS_SWEEP_EN
      dend_l_nx = dend_l;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               dir_l_nx = dir;
               dlt_l_nx = delta;
               set_l_nx = sat_settle(settle);
`ifdef MIS_SWEEP_EN
               dend_l_nx = delta_end;
`endif
               busy_nx  = 1'b1;
               cnt_nx   = '0;
               state_nx = ARM;
            end
         end
         ARM: begin
            // Park both inputs at the pre-edge level for S cycles.
            a1_nx = ~dir_l;
            a2_nx = ~dir_l;
            if (cnt == set_l - ONE) begin
               cnt_nx   = '0;
               state_nx = LEAD;
            end else begin
               cnt_nx = cnt + ONE;
            end
         end
         LEAD: begin
            trig_nx = 1'b1;
            cnt_nx  = ONE;
            if (dlt_zero) begin
               a1_nx    = dir_l;
               a2_nx    = dir_l;
               state_nx = HOLD;
            end else begin
               if (dlt_neg) a2_nx = dir_l;
               else         a1_nx = dir_l;
               state_nx = SKEW;
            end
         end
         SKEW: begin
            // cnt equals the number of cycles elapsed since the leading edge.
            if (cnt == skew) begin
               state_nx = TRAIL;
               if (dlt_neg) a1_nx = dir_l;
               else         a2_nx = dir_l;
               cnt_nx   = ONE;
               state_nx = HOLD;
            end else begin
               cnt_nx = cnt + ONE;
            end
         end
         TRAIL: begin
            // The trailing edge is issued from SKEW so it lands exactly on
            // the skew count; this state is only a safe fall-through.
            cnt_nx   = ONE;
            state_nx = HOLD;
         end
         HOLD: begin
            if (cnt == set_l) begin
               if (more_pairs) begin
                  dlt_l_nx = dlt_l + ONE;
                  cnt_nx   = '0;
                  state_nx = ARM;
               end else begin
                  cnt_nx   = '0;
                  state_nx = FIN;
               end
            end else begin
               cnt_nx = cnt + ONE;
            end
         end
         FIN: begin
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            cnt_nx   = '0;
            state_nx = IDLE;
         end
         default: begin
            cnt_nx   = '0;
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mis_stim_gen.sv
// Directed bench for mis_stim_gen (CNT_W=8, SETTLE_MIN=1). Edge numbers are
// counted from the start-accepting edge (edge 0). The sweep section is
// compiled only when MIS_SWEEP_EN is defined.
`timescale 1ns/1ps

module tb_mis_stim_gen;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic signed [7:0] delta;
   logic              dir;
   logic        [7:0] settle;
`ifdef MIS_SWEEP_EN
   logic signed [7:0] delta_end;
`endif
   logic              myinA1, myinA2, trig, busy, done;

   int n_chk  = 0;
   int n_pass = 0;

   mis_stim_gen #(.CNT_W(8), .SETTLE_MIN(1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .delta    (delta),
      .dir      (dir),
      .settle   (settle),
`ifdef MIS_SWEEP_EN
      .delta_end(delta_end),
`endif
      .myinA1   (myinA1),
      .myinA2   (myinA2),
      .trig     (trig),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_chk++;
      if (obs == exp_v) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
   endtask

   // One start, then watch edges 1..N until done; compare event edges.
   task automatic run_pair(input string nm, input logic d_dir, input int d_delta,
                           input int d_set, input int e_a1, input int e_a2,
                           input int e_trig, input int e_done);
      int a1e, a2e, te, tc, de;
      @(negedge clk);
      start  = 1'b1;
      dir    = d_dir;
      delta  = 8'(d_delta);
      settle = 8'(d_set);
`ifdef MIS_SWEEP_EN
      delta_end = 8'(d_delta);
`endif
      @(posedge clk); #1;
      start = 1'b0;
      a1e = 0; a2e = 0; te = 0; tc = 0; de = 0;
      for (int j = 1; j <= 400 && de == 0; j++) begin
         @(posedge clk); #1;
         if (j == 1) begin
            chk({nm, " arm_a1"}, int'(myinA1), int'(!d_dir));
            chk({nm, " arm_a2"}, int'(myinA2), int'(!d_dir));
            chk({nm, " busy"}, int'(busy), 1);
         end
         if (a1e == 0 && myinA1 == d_dir) a1e = j;
         if (a2e == 0 && myinA2 == d_dir) a2e = j;
         if (trig) begin
            tc++;
            if (te == 0) te = j;
         end
         if (done) begin
            de = j;
            chk({nm, " busy_at_done"}, int'(busy), 0);
         end
      end
      chk({nm, " a1_edge"}, a1e, e_a1);
      chk({nm, " a2_edge"}, a2e, e_a2);
      chk({nm, " trig_edge"}, te, e_trig);
      chk({nm, " trig_count"}, tc, 1);
      chk({nm, " done_edge"}, de, e_done);
      @(posedge clk); #1;
      chk({nm, " done_1cyc"}, int'(done), 0);
      chk({nm, " a1_final"}, int'(myinA1), int'(d_dir));
      chk({nm, " a2_final"}, int'(myinA2), int'(d_dir));
   endtask

   initial begin
      int de;
      rst_n = 1'b0; start = 1'b0; dir = 1'b0; delta = '0; settle = '0;
`ifdef MIS_SWEEP_EN
      delta_end = '0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a1", int'(myinA1), 0);
      chk("rst_a2", int'(myinA2), 0);
      chk("rst_trig", int'(trig), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_busy", int'(busy), 0);

      //        name   dir    delta settle A1   A2   trig done
      run_pair("v035", 1'b1,   3,   4,     5,   8,   5,   13);
      run_pair("v036", 1'b0,  -2,   2,     5,   3,   3,   8);
      run_pair("v037", 1'b1,   0,   0,     2,   2,   2,   4);
      run_pair("v038", 1'b1, -128,  1,     130, 2,   2,   132);
      run_pair("vp1",  1'b0,   1,   3,     4,   5,   4,   9);

      // Reset in the middle of SKEW: dir=1, delta=+5, settle=2 -> lead at 3.
      @(negedge clk);
      start = 1'b1; dir = 1'b1; delta = 8'sd5; settle = 8'd2;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("pre_rst_a1", int'(myinA1), 1);
      chk("pre_rst_a2", int'(myinA2), 0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_a1", int'(myinA1), 0);
      chk("async_rst_busy", int'(busy), 0);
      de = 0;
      for (int j = 0; j < 3; j++) begin
         @(posedge clk); #1;
         if (done) de++;
      end
      chk("rst_no_done", de, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_pair("post_rst", 1'b1, 3, 4, 5, 8, 5, 13);

      // start held high: the cycle after done must re-accept immediately.
      @(negedge clk);
      start = 1'b1; dir = 1'b1; delta = 8'sd0; settle = 8'd0;
      de = 0;
      for (int j = 0; j < 50 && de == 0; j++) begin
         @(posedge clk); #1;
         if (done) de = 1;
      end
      chk("hold_start_done1", de, 1);
      @(posedge clk); #1;
      chk("hold_start_rerun", int'(busy), 1);
      start = 1'b0;
      de = 0;
      for (int j = 0; j < 50 && de == 0; j++) begin
         @(posedge clk); #1;
         if (done) de = 1;
      end
      chk("hold_start_done2", de, 1);

`ifdef MIS_SWEEP_EN
      // delta -1 .. +1, settle 2: trig at 3, 9, 14, single done at 18.
      begin
         int tc, te[3], dc, dedge, busy_lo;
         @(negedge clk);
         start = 1'b1; dir = 1'b1; delta = -8'sd1; delta_end = 8'sd1; settle = 8'd2;
         @(posedge clk); #1;
         start = 1'b0;
         tc = 0; dc = 0; dedge = 0; busy_lo = 0;
         te[0] = 0; te[1] = 0; te[2] = 0;
         for (int j = 1; j <= 30; j++) begin
            @(posedge clk); #1;
            if (trig) begin
               if (tc < 3) te[tc] = j;
               tc++;
            end
            if (done) begin
               dc++;
               dedge = j;
            end
            if (j < 18 && !busy) busy_lo++;
         end
         chk("sweep_trig_count", tc, 3);
         chk("sweep_trig0", te[0], 3);
         chk("sweep_trig1", te[1], 9);
         chk("sweep_trig2", te[2], 14);
         chk("sweep_done_count", dc, 1);
         chk("sweep_done_edge", dedge, 18);
         chk("sweep_busy_gaps", busy_lo, 0);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
